// File: rtl/ddr2_rw_sched.sv
// Read/write arbiter for a DDR2 controller: round-robin grant, one transaction
// in flight, trigger/ready/done handshake to the masters and a WAIT watchdog.
module ddr2_rw_sched #(
    parameter int unsigned ADDR_WIDTH = 26,
    parameter logic [15:0] TIMEOUT    = 16'd8191
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_end,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [7:0]            wr_req_len,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_req_addr,
    input  logic [7:0]            rd_req_len,
    output logic                  wr_ack,
    output logic                  rd_ack,
    output logic                  wr_cmpl,
    output logic                  rd_cmpl,
    output logic                  wr_trig,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_len,
    input  logic                  wr_ready,
    input  logic                  wr_done,
    output logic                  rd_trig,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [7:0]            rd_len,
    input  logic                  rd_ready,
    input  logic                  rd_done,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int unsigned LEN_W = 8;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 16'd1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ISSUE, S_WR_WAIT, S_RD_ISSUE, S_RD_WAIT
    } state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_last_rd, w_last_rd_nxt;
    logic                  r_zero, w_zero_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic                  r_err, w_err_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_wr_ack, w_wr_ack_nxt, r_rd_ack, w_rd_ack_nxt;
    logic                  r_wr_cmpl, w_wr_cmpl_nxt, r_rd_cmpl, w_rd_cmpl_nxt;
    logic                  r_wr_trig, w_wr_trig_nxt, r_rd_trig, w_rd_trig_nxt;
    logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_nxt, r_rd_addr, w_rd_addr_nxt;
    logic [LEN_W-1:0]      r_wr_len, w_wr_len_nxt, r_rd_len, w_rd_len_nxt;
    logic                  w_grant_wr, w_grant_rd;

    // Round-robin: on contention the side not granted last time wins.
    assign w_grant_wr = init_end && wr_req && (!rd_req || r_last_rd);
    assign w_grant_rd = init_end && rd_req && !w_grant_wr;

    always_comb begin
        w_state_nxt   = r_state;
        w_last_rd_nxt = r_last_rd;
        w_zero_nxt    = r_zero;
        w_cnt_nxt     = r_cnt;
        w_err_nxt     = r_err;
        w_wr_trig_nxt = r_wr_trig;
        w_rd_trig_nxt = r_rd_trig;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_len_nxt  = r_wr_len;
        w_rd_addr_nxt = r_rd_addr;
        w_rd_len_nxt  = r_rd_len;
        w_wr_ack_nxt  = 1'b0;
        w_rd_ack_nxt  = 1'b0;
        w_wr_cmpl_nxt = 1'b0;
        w_rd_cmpl_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_wr) begin
                    w_state_nxt   = S_WR_ISSUE;
                    w_last_rd_nxt = 1'b0;
                    w_wr_ack_nxt  = 1'b1;
                    w_wr_addr_nxt = wr_req_addr;
                    w_wr_len_nxt  = wr_req_len;
                    w_zero_nxt    = (wr_req_len == 8'd0);
                    w_wr_trig_nxt = (wr_req_len != 8'd0);
                end else if (w_grant_rd) begin
                    w_state_nxt   = S_RD_ISSUE;
                    w_last_rd_nxt = 1'b1;
                    w_rd_ack_nxt  = 1'b1;
                    w_rd_addr_nxt = rd_req_addr;
                    w_rd_len_nxt  = rd_req_len;
                    w_zero_nxt    = (rd_req_len == 8'd0);
                    w_rd_trig_nxt = (rd_req_len != 8'd0);
                end
            end
            // A zero-length grant completes straight out of ISSUE without a trigger.
            S_WR_ISSUE: begin
                if (r_zero) begin
                    w_state_nxt   = S_IDLE;
                    w_wr_cmpl_nxt = 1'b1;
                end else if (wr_ready) begin
                    w_state_nxt   = S_WR_WAIT;
                    w_wr_trig_nxt = 1'b0;
                    w_cnt_nxt     = '0;
                end
            end
            S_WR_WAIT: begin
                if (wr_done) begin
                    w_state_nxt   = S_IDLE;
                    w_wr_cmpl_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            S_RD_ISSUE: begin
                if (r_zero) begin
                    w_state_nxt   = S_IDLE;
                    w_rd_cmpl_nxt = 1'b1;
                end else if (rd_ready) begin
                    w_state_nxt   = S_RD_WAIT;
                    w_rd_trig_nxt = 1'b0;
                    w_cnt_nxt     = '0;
                end
            end
            // Done takes priority over the watchdog on the expiry edge.
            S_RD_WAIT: begin
                if (rd_done) begin
                    w_state_nxt   = S_IDLE;
                    w_rd_cmpl_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_last_rd <= 1'b1;
            r_zero    <= 1'b0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_wr_ack  <= 1'b0;
            r_rd_ack  <= 1'b0;
            r_wr_cmpl <= 1'b0;
            r_rd_cmpl <= 1'b0;
            r_wr_trig <= 1'b0;
            r_rd_trig <= 1'b0;
            r_wr_addr <= '0;
            r_wr_len  <= '0;
            r_rd_addr <= '0;
            r_rd_len  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_last_rd <= w_last_rd_nxt;
            r_zero    <= w_zero_nxt;
            r_cnt     <= w_cnt_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= w_busy_nxt;
            r_wr_ack  <= w_wr_ack_nxt;
            r_rd_ack  <= w_rd_ack_nxt;
            r_wr_cmpl <= w_wr_cmpl_nxt;
            r_rd_cmpl <= w_rd_cmpl_nxt;
            r_wr_trig <= w_wr_trig_nxt;
            r_rd_trig <= w_rd_trig_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_len  <= w_wr_len_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_rd_len  <= w_rd_len_nxt;
        end
    end

    assign wr_ack      = r_wr_ack;
    assign rd_ack      = r_rd_ack;
    assign wr_cmpl     = r_wr_cmpl;
    assign rd_cmpl     = r_rd_cmpl;
    assign wr_trig     = r_wr_trig;
    assign rd_trig     = r_rd_trig;
    assign wr_addr     = r_wr_addr;
    assign wr_len      = r_wr_len;
    assign rd_addr     = r_rd_addr;
    assign rd_len      = r_rd_len;
    assign busy        = r_busy;
    assign timeout_err = r_err;

endmodule

// File: tb/tb_ddr2_rw_sched.sv
// Scoreboard bench for ddr2_rw_sched: a cycle-level timeline model predicts
// acks, completions, timeouts and busy/trigger levels; a monitor compares.
module tb_ddr2_rw_sched;

    localparam int AW = 26;
    localparam int TO = 16;

    logic          clk = 1'b0, rst_n = 1'b1, init_end = 1'b0;
    logic          wr_req = 1'b0, rd_req = 1'b0;
    logic [AW-1:0] wr_req_addr = '0, rd_req_addr = '0;
    logic [7:0]    wr_req_len = '0, rd_req_len = '0;
    logic          wr_ready = 1'b0, wr_done = 1'b0, rd_ready = 1'b0, rd_done = 1'b0;
    logic          wr_ack, rd_ack, wr_cmpl, rd_cmpl, wr_trig, rd_trig, busy, timeout_err;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [7:0]    wr_len, rd_len;

    ddr2_rw_sched #(.ADDR_WIDTH(AW), .TIMEOUT(16'(TO))) dut (
        .clk(clk), .rst_n(rst_n), .init_end(init_end),
        .wr_req(wr_req), .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len),
        .rd_req(rd_req), .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
        .wr_ack(wr_ack), .rd_ack(rd_ack), .wr_cmpl(wr_cmpl), .rd_cmpl(rd_cmpl),
        .wr_trig(wr_trig), .wr_addr(wr_addr), .wr_len(wr_len),
        .wr_ready(wr_ready), .wr_done(wr_done),
        .rd_trig(rd_trig), .rd_addr(rd_addr), .rd_len(rd_len),
        .rd_ready(rd_ready), .rd_done(rd_done),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ev bits: {wr_ack, rd_ack, wr_cmpl, rd_cmpl, timeout}
    typedef struct {
        int            cyc;
        logic [4:0]    ev;
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } exp_t;

    exp_t          exp_q[$];
    logic [2:0]    exp_st[int];
    int            n_chk = 0, n_pass = 0;
    bit            mon_en = 1'b0;
    bit            m_last_rd = 1'b1;
    logic          m_err = 1'b0;
    logic [AW-1:0] m_wr_addr = '0, m_rd_addr = '0;
    logic [7:0]    m_wr_len = '0, m_rd_len = '0;
    logic          prev_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_levels"}, 64'({wr_ack, rd_ack, wr_cmpl, rd_cmpl, wr_trig, rd_trig, busy, timeout_err}), 64'(0));
        chk({tag, "_wr_bus"}, 64'({wr_addr, wr_len}), 64'(0));
        chk({tag, "_rd_bus"}, 64'({rd_addr, rd_len}), 64'(0));
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [7:0] rlen();
        return ($urandom % 6 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    endfunction

    function automatic int rdel();
        return ($urandom % 8 == 0) ? int'($urandom_range(TO, TO + 4)) : int'($urandom_range(0, TO - 1));
    endfunction

    // Monitor: pops the events predicted for this cycle and compares levels
    exp_t       me;
    logic [4:0] eo, ee;
    logic [2:0] se;
    always @(negedge clk) begin
        eo = {wr_ack, rd_ack, wr_cmpl, rd_cmpl, timeout_err & ~prev_err};
        prev_err = timeout_err;
        if (mon_en) begin
            ee = '0;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                me = exp_q.pop_front();
                chk("stale_event", 64'(cyc), 64'(me.cyc));
            end
            while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                me = exp_q.pop_front();
                if (me.ev[4]) begin m_wr_addr = me.addr; m_wr_len = me.len; end
                if (me.ev[3]) begin m_rd_addr = me.addr; m_rd_len = me.len; end
                if (me.ev[0]) begin ee[0] = ~m_err; m_err = 1'b1; end
                ee[4:1] = ee[4:1] | me.ev[4:1];
            end
            se = exp_st.exists(cyc) ? exp_st[cyc] : 3'b000;
            if (exp_st.exists(cyc)) exp_st.delete(cyc);
            if (eo != 5'd0 || ee != 5'd0) chk("events", 64'(eo), 64'(ee));
            chk("busy_trig_err", 64'({busy, wr_trig, rd_trig, timeout_err}), 64'({se, m_err}));
            chk("wr_bus", 64'({wr_addr, wr_len}), 64'({m_wr_addr, m_wr_len}));
            chk("rd_bus", 64'({rd_addr, rd_len}), 64'({m_rd_addr, m_rd_len}));
        end
    end

    task automatic clear_inputs();
        wr_req = 0; rd_req = 0; wr_ready = 0; wr_done = 0; rd_ready = 0; rd_done = 0;
    endtask

    // One scenario: plan the whole timeline, then play client and masters.
    task automatic run(input bit w_p, input bit r_p,
                       input logic [AW-1:0] wa, input logic [7:0] wl, input int wr_r, input int wr_d,
                       input logic [AW-1:0] ra, input logic [7:0] rl, input int rd_r, input int rd_d,
                       input int pre, input int gap, input int rst_off);
        bit            sd[2];
        logic [AW-1:0] ad[2];
        logic [7:0]    ln[2];
        int            rr[2], dd[2], ak[2], en[2];
        int            n, last, c, wak, rak;
        logic          own_r, own_d, oth_r, oth_d;
        exp_t          e;
        wr_req_addr = wa; wr_req_len = wl; rd_req_addr = ra; rd_req_len = rl;
        if (pre > 0) init_end = 0;
        wr_req = w_p; rd_req = r_p;
        if (pre > 0) repeat (pre) step();
        init_end = 1;
        if (w_p && (!r_p || m_last_rd)) begin
            sd[0] = 0; ad[0] = wa; ln[0] = wl; rr[0] = wr_r; dd[0] = wr_d; n = 1;
            if (r_p) begin sd[1] = 1; ad[1] = ra; ln[1] = rl; rr[1] = rd_r; dd[1] = rd_d; n = 2; end
        end else begin
            sd[0] = 1; ad[0] = ra; ln[0] = rl; rr[0] = rd_r; dd[0] = rd_d; n = 1;
            if (w_p) begin sd[1] = 0; ad[1] = wa; ln[1] = wl; rr[1] = wr_r; dd[1] = wr_d; n = 2; end
        end
        m_last_rd = sd[n-1];
        ak[0] = cyc + 1;
        for (int k = 0; k < n; k++) begin
            if (k > 0) ak[k] = en[k-1] + 1 + gap;
            if (ln[k] == 8'd0)  en[k] = ak[k] + 1;
            else if (dd[k] < TO) en[k] = ak[k] + rr[k] + dd[k] + 1;
            else                 en[k] = ak[k] + rr[k] + TO;
            for (int t = ak[k]; t < en[k]; t++)
                exp_st[t] = {1'b1, !sd[k] && ln[k] != 0 && t < ak[k] + rr[k],
                                    sd[k] && ln[k] != 0 && t < ak[k] + rr[k]};
            e.cyc = ak[k]; e.ev = sd[k] ? 5'b01000 : 5'b10000; e.addr = ad[k]; e.len = ln[k];
            exp_q.push_back(e);
            e.cyc = en[k];
            e.ev  = (ln[k] == 8'd0 || dd[k] < TO) ? (sd[k] ? 5'b00010 : 5'b00100) : 5'b00001;
            exp_q.push_back(e);
        end
        wak = !w_p ? -1 : (sd[0] ? ak[1] : ak[0]);
        rak = !r_p ? -1 : (sd[0] ? ak[0] : ak[1]);
        last = en[n-1];
        if (gap > 0 && en[0] + gap > last) last = en[0] + gap;
        while (cyc <= last) begin
            c = cyc;
            wr_req = w_p && c < wak;
            rd_req = r_p && c < rak;
            if (gap > 0 && c == ak[0]) init_end = 0;
            if (gap > 0 && c == en[0] + gap) init_end = 1;
            wr_ready = 0; wr_done = 0; rd_ready = 0; rd_done = 0;
            for (int k = 0; k < n; k++) begin
                if (c >= ak[k] && c < en[k]) begin
                    own_r = 0; own_d = 0; oth_r = rb(); oth_d = rb();
                    if (ln[k] == 8'd0) begin own_r = rb(); own_d = rb(); end
                    else if (c < ak[k] + rr[k] - 1) own_d = rb();
                    else if (c == ak[k] + rr[k] - 1) own_r = 1;
                    else begin
                        own_r = rb();
                        own_d = (dd[k] < TO) && (c == ak[k] + rr[k] + dd[k]);
                    end
                    if (sd[k]) begin rd_ready = own_r; rd_done = own_d; wr_ready = oth_r; wr_done = oth_d; end
                    else       begin wr_ready = own_r; wr_done = own_d; rd_ready = oth_r; rd_done = oth_d; end
                end
            end
            if (rst_off > 0 && c == ak[0] + rr[0] + rst_off) begin
                rst_n = 0;
                #1;
                chk_zero("mid_reset");
                mon_en = 0;
                exp_q.delete(); exp_st.delete();
                m_last_rd = 1; m_err = 0;
                m_wr_addr = '0; m_wr_len = '0; m_rd_addr = '0; m_rd_len = '0;
                clear_inputs();
                repeat (3) step();
                rst_n = 1;
                step();
                mon_en = 1;
                return;
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic idle_noise(input int k);
        repeat (k) begin
            wr_ready = rb(); wr_done = rb(); rd_ready = rb(); rd_done = rb();
            step();
        end
        clear_inputs();
    endtask

    initial begin
        int sel;
        #1 rst_n = 0;
        #1 chk_zero("reset");
        repeat (3) step();
        rst_n = 1;
        step();
        mon_en = 1;
        // Requests held while uninitialised, then both granted write-first
        run(1, 1, 26'($urandom), 8'd5, 2, 3, 26'($urandom), 8'd7, 1, 0, 100, 0, 0);
        // Single write: four trigger cycles, completes inside the watchdog
        run(1, 0, 26'h40, 8'd32, 4, 14, '0, '0, 1, 0, 0, 0, 0);
        repeat (4) run(1, 1, 26'($urandom), 8'($urandom_range(1, 255)), int'($urandom_range(1, 4)),
                       int'($urandom_range(0, TO - 1)), 26'($urandom), 8'($urandom_range(1, 255)),
                       int'($urandom_range(1, 4)), int'($urandom_range(0, TO - 1)), 0, 0, 0);
        // Read with done withheld, then done on the last legal WAIT edge
        run(0, 1, '0, '0, 1, 0, 26'h1234, 8'd16, 2, 30, 0, 0, 0);
        run(0, 1, '0, '0, 1, 0, 26'h55, 8'd3, 1, TO - 1, 0, 0, 0);
        run(0, 1, '0, '0, 1, 0, 26'h777, 8'd0, 1, 0, 0, 0, 0);
        run(1, 1, 26'h100, 8'd9, 3, 5, 26'h200, 8'd4, 2, 2, 0, 3, 0);
        idle_noise(4);
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom % 3);
            run(sel != 1, sel != 0, 26'($urandom), rlen(), int'($urandom_range(1, 5)), rdel(),
                26'($urandom), rlen(), int'($urandom_range(1, 5)), rdel(), 0,
                ($urandom % 5 == 0) ? int'($urandom_range(1, 4)) : 0, 0);
            idle_noise(int'($urandom_range(1, 3)));
        end
        // Reset in the middle of a write WAIT
        run(1, 0, 26'h3abc, 8'd8, 2, 40, '0, '0, 1, 0, 0, 0, 3);
        idle_noise(3);
        run(1, 1, 26'h11, 8'd2, 1, 1, 26'h22, 8'd2, 1, 1, 0, 0, 0);
        repeat (5) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
